// File: rtl/jtag_scan_sequencer.sv
// jtag_scan_sequencer: drives one IR+DR scan per start through a modelled 1149.1 TAP.
// Define JTAG_TAP_RESET_EN to prefix each scan with a TAP reset (5x tms=1, then tms=0).
module jtag_scan_sequencer #(
  parameter int MAX_VECTOR_WIDTH = 32,
  parameter int MAX_INSTR_WIDTH = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [MAX_INSTR_WIDTH-1:0]  instruction,
  input  logic [2:0]                  instructionWidth,
  input  logic [MAX_VECTOR_WIDTH-1:0] testVector,
  input  logic [5:0]                  vectorWidth,
  input  logic                        tdo,
  output logic                        tms,
  output logic                        tdi,
  output logic                        busy,
  output logic                        done,
  output logic                        error,
  output logic [MAX_VECTOR_WIDTH-1:0] captureVector,
  output logic [3:0]                  tapState
);
  typedef enum logic [2:0] {INIT, IDLE, TAPRST, GOIR, SHIR, GODR, SHDR, GOIDLE} ctrlState_e;
`ifdef JTAG_TAP_RESET_EN
  localparam ctrlState_e FIRST = TAPRST;
`else
  localparam ctrlState_e FIRST = GOIR;
`endif
  ctrlState_e state, nextState;
  logic [5:0] cnt, nextCnt, lastIr, lastDr;
  logic [MAX_INSTR_WIDTH-1:0] irQ;
  logic [MAX_VECTOR_WIDTH-1:0] drQ, capShift;
  logic [2:0] iwQ;
  logic [5:0] vwQ;
  logic nextBusy, nextDone, nextErr, nextTms, nextTdi, launch, legal;
  // state/cnt are registered together with tms/tdi, so they always name the bit on the wire
  function automatic logic [3:0] tapNext(input logic [3:0] s, input logic m);
    case (s)
      4'd0: tapNext = m ? 4'd0 : 4'd1;
      4'd1, 4'd9, 4'd15: tapNext = m ? 4'd2 : 4'd1;
      4'd2: tapNext = m ? 4'd3 : 4'd10;
      4'd3: tapNext = m ? 4'd0 : 4'd4;
      4'd4, 4'd5: tapNext = m ? 4'd6 : 4'd5;
      4'd6: tapNext = m ? 4'd9 : 4'd7;
      4'd7: tapNext = m ? 4'd8 : 4'd7;
      4'd8: tapNext = m ? 4'd9 : 4'd5;
      4'd10, 4'd11: tapNext = m ? 4'd12 : 4'd11;
      4'd12: tapNext = m ? 4'd15 : 4'd13;
      4'd13: tapNext = m ? 4'd14 : 4'd13;
      default: tapNext = m ? 4'd15 : 4'd11;
    endcase
  endfunction
  assign legal = instructionWidth inside {3'd3, 3'd4, 3'd5} && vectorWidth inside {6'd8, 6'd16, 6'd24, 6'd32};
  assign lastIr = {3'b000, iwQ} - 6'd1;
  assign lastDr = vwQ - 6'd1;
  always_comb begin
    nextState = state;
    nextCnt = cnt + 6'd1;
    nextBusy = 1'b1;
    nextDone = 1'b0;
    nextErr = 1'b0;
    launch = 1'b0;
    case (state)
      INIT: begin
        nextState = cnt == 6'd0 ? INIT : IDLE;
        nextBusy = cnt == 6'd0;
      end
      IDLE: begin
        nextCnt = 6'd0;
        launch = start & legal;
        nextErr = start & ~legal;
        nextBusy = launch;
        nextState = launch ? FIRST : IDLE;
      end
      TAPRST: if (cnt == 6'd5) begin nextState = GOIR; nextCnt = 6'd0; end
      GOIR: if (cnt == 6'd3) begin nextState = SHIR; nextCnt = 6'd0; end
      SHIR: if (cnt == lastIr) begin nextState = GODR; nextCnt = 6'd0; end
      GODR: if (cnt == 6'd3) begin nextState = SHDR; nextCnt = 6'd0; end
      SHDR: if (cnt == lastDr) begin nextState = GOIDLE; nextCnt = 6'd0; end
      default: begin
        nextState = IDLE;
        nextCnt = 6'd0;
        nextBusy = 1'b0;
        nextDone = 1'b1;
      end
    endcase
    nextTms = nextState == TAPRST ? nextCnt < 6'd5 :
              (nextState == GOIR || nextState == GODR) ? nextCnt < 6'd2 :
              nextState == SHIR ? nextCnt == lastIr :
              nextState == SHDR ? nextCnt == lastDr :
              nextState == GOIDLE;
    nextTdi = nextState == SHIR ? |(irQ & (MAX_INSTR_WIDTH'(1) << nextCnt)) :
              nextState == SHDR ? |(drQ & (MAX_VECTOR_WIDTH'(1) << nextCnt)) : 1'b0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
      cnt <= 6'd0;
      tms <= 1'b1;
      tdi <= 1'b0;
      busy <= 1'b1;
      done <= 1'b0;
      error <= 1'b0;
      captureVector <= '0;
      capShift <= '0;
      tapState <= 4'd0;
      irQ <= '0;
      drQ <= '0;
      iwQ <= 3'd0;
      vwQ <= 6'd0;
    end else begin
      state <= nextState;
      cnt <= nextCnt;
      tms <= nextTms;
      tdi <= nextTdi;
      busy <= nextBusy;
      done <= nextDone;
      error <= nextErr;
      tapState <= tapNext(tapState, tms);
      if (launch) begin
        irQ <= instruction;
        drQ <= testVector;
        iwQ <= instructionWidth;
        vwQ <= vectorWidth;
        capShift <= '0;
      end else if (state == SHDR) capShift <= capShift | (MAX_VECTOR_WIDTH'(tdo) << cnt);
      if (nextDone) captureVector <= capShift;
    end
  end
endmodule

// File: tb/tb_jtag_scan_sequencer.sv
// tb_jtag_scan_sequencer: directed scans against a per-cycle bit-stream model of the sequencer.
module tb_jtag_scan_sequencer;
`ifdef JTAG_TAP_RESET_EN
  localparam int PRE = 6;
`else
  localparam int PRE = 0;
`endif
  logic clk = 0, reset = 1, start = 0, tdo;
  logic [4:0] instruction = 0;
  logic [2:0] instructionWidth = 3'd5;
  logic [31:0] testVector = 0;
  logic [5:0] vectorWidth = 6'd8;
  logic tms, tdi, busy, done, error;
  logic [31:0] captureVector;
  logic [3:0] tapState;
  int tdoMode = 0;
  assign tdo = tdoMode == 0 ? tdi : (tdoMode == 1);

  jtag_scan_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .instruction(instruction),
    .instructionWidth(instructionWidth), .testVector(testVector), .vectorWidth(vectorWidth),
    .tdo(tdo), .tms(tms), .tdi(tdi), .busy(busy), .done(done), .error(error),
    .captureVector(captureVector), .tapState(tapState)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic tms, tdi, busy, done, err; logic [31:0] cap;} exp_t;
  exp_t q[$];
  exp_t e;
  int passed = 0, total = 0;
  bit checking = 0;
  int mTap = 0;
  logic [31:0] mCap = 0;
  // IEEE 1149.1 transition table: tapNextTbl[state][tms]
  int tapNextTbl[16][2] = '{'{1,0}, '{1,2}, '{10,3}, '{4,0}, '{5,6}, '{5,6}, '{7,9}, '{7,8},
                            '{5,9}, '{1,2}, '{11,12}, '{11,12}, '{13,15}, '{13,14}, '{11,15}, '{1,2}};
  int lat;
  logic [4:0] ir;
  logic [1:0] lt;
  bit seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
  endtask

  always @(negedge clk) if (checking) begin
    e = q.size() != 0 ? q.pop_front() : '{tms:0, tdi:0, busy:0, done:0, err:0, cap:mCap};
    if (e.done) mCap = e.cap;
    chk("tms", tms, e.tms);
    chk("tdi", tdi, e.tdi);
    chk("busy", busy, e.busy);
    chk("done", done, e.done);
    chk("error", error, e.err);
    chk("captureVector", captureVector, mCap);
    chk("tapState", tapState, mTap);
    mTap = tapNextTbl[mTap][e.tms];
  end

  task automatic doReset();
    checking = 0; q.delete(); reset = 1; start = 0;
    repeat (2) @(negedge clk);
    chk("rst_tms", tms, 1); chk("rst_tdi", tdi, 0); chk("rst_busy", busy, 1); chk("rst_done", done, 0);
    chk("rst_error", error, 0); chk("rst_cap", captureVector, 0); chk("rst_tap", tapState, 0);
    #1 reset = 0;
    @(negedge clk);
    chk("init_tms", tms, 0); chk("init_busy", busy, 1); chk("init_tap", tapState, 0);
    @(negedge clk);
    chk("idle_tms", tms, 0); chk("idle_busy", busy, 0); chk("idle_tap", tapState, 1); chk("idle_done", done, 0);
    mTap = 1; mCap = 0;
    #1 checking = 1;
  endtask

  task automatic runScan(input logic [4:0] ins, input int iw, input logic [31:0] vec, input int vw,
                         input int mode, input bit now, output int latency, output logic [4:0] irBits,
                         output logic [1:0] lastTms);
    bit tl[$], td[$];
    logic [31:0] mask, cap;
    mask = vw == 32 ? 32'hFFFF_FFFF : (32'd1 << vw) - 32'd1;
    cap = mode == 0 ? vec & mask : mode == 1 ? mask : 32'd0;
    for (int i = 0; i < PRE; i++) begin tl.push_back(i < 5); td.push_back(0); end
    for (int i = 0; i < 4; i++) begin tl.push_back(i < 2); td.push_back(0); end
    for (int i = 0; i < iw; i++) begin tl.push_back(i == iw - 1); td.push_back(ins[i]); end
    for (int i = 0; i < 4; i++) begin tl.push_back(i < 2); td.push_back(0); end
    for (int i = 0; i < vw; i++) begin tl.push_back(i == vw - 1); td.push_back(vec[i]); end
    tl.push_back(1); td.push_back(0); tl.push_back(0); td.push_back(0);
    if (!now) begin @(negedge clk); #1; end
    tdoMode = mode; instruction = ins; instructionWidth = 3'(iw); testVector = vec; vectorWidth = 6'(vw); start = 1;
    for (int i = 0; i < tl.size(); i++)
      q.push_back('{tms:tl[i], tdi:td[i], busy:(i != tl.size() - 1), done:(i == tl.size() - 1), err:0, cap:cap});
    latency = 0; irBits = 0; lastTms = 0;
    do begin
      @(negedge clk); #1;
      start = 0;
      latency++;
      if (latency == 3) begin start = 1; instruction = ~ins; testVector = ~vec; end
      if (latency > PRE + 4 && latency <= PRE + 4 + iw) irBits[latency - PRE - 5] = tdi;
      lastTms = {lastTms[0], tms};
    end while (!done && latency < 200);
  endtask

  initial begin
    logic [2:0] badIw[4];
    logic [5:0] badVw[4];
    badIw = '{3'd5, 3'd2, 3'd7, 3'd4};
    badVw = '{6'd12, 6'd8, 6'd16, 6'd0};
    doReset();
    runScan(5'b00110, 5, 32'h0000_00A5, 8, 0, 0, lat, ir, lt);
    chk("lat_a5", lat, 23 + PRE); chk("ir_a5", ir, 5'b00110); chk("cap_a5", captureVector, 32'h0000_00A5);
    runScan(5'b00101, 3, 32'hDEAD_BEEF, 32, 1, 0, lat, ir, lt);
    chk("lat_dead", lat, 45 + PRE); chk("cap_dead", captureVector, 32'hFFFF_FFFF); chk("tail_tms", lt, 2'b10);
    runScan(5'b01010, 4, 32'h0000_3C3C, 16, 2, 1, lat, ir, lt);
    chk("lat_b2b", lat, 30 + PRE); chk("cap_zero", captureVector, 0); chk("ir_b2b", ir, 5'b01010);
    runScan(5'b11001, 5, 32'h12C3_5A96, 24, 0, 0, lat, ir, lt);
    chk("lat_24", lat, 39 + PRE); chk("cap_24", captureVector, 32'h00C3_5A96);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      instructionWidth = badIw[k]; vectorWidth = badVw[k]; start = 1;
      q.push_back('{tms:0, tdi:0, busy:0, done:0, err:1, cap:0});
      @(negedge clk); #1;
      start = 0;
      chk("err_pulse", error, 1); chk("err_busy", busy, 0); chk("err_tms", tms, 0);
      @(negedge clk); #1;
      chk("err_once", error, 0);
    end
    @(negedge clk); #1;
    checking = 0; q.delete(); seen = 0;
    instruction = 5'b10011; instructionWidth = 3'd5; testVector = 32'h5A; vectorWidth = 6'd8; tdoMode = 0; start = 1;
    for (int c = 1; c <= PRE + 18; c++) begin
      @(negedge clk); #1;
      start = 0;
      seen |= done;
    end
    chk("shdr4_tdi", tdi, 1);
    reset = 1;
    @(negedge clk); #1;
    seen |= done;
    chk("abort_tms", tms, 1); chk("abort_cap", captureVector, 0); chk("abort_busy", busy, 1);
    chk("abort_tap", tapState, 0); chk("abort_nodone", seen, 0);
    doReset();
    runScan(5'b00001, 3, 32'h0000_0081, 8, 0, 0, lat, ir, lt);
    chk("lat_rec", lat, 21 + PRE); chk("cap_rec", captureVector, 32'h81);
    repeat (3) @(negedge clk);
    #1 checking = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end
endmodule
